memory_responder: RTL
=====================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter: DEPTH, 512, number of 32-bit words.
REQ-002 Parameter: WAIT_CYCLES, 2, wait-state count per access, legal range 1..15.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clock  input  1  system clock, all state changes on rising edge.
REQ-005 clr  input  1  asynchronous active-high reset.
REQ-006 read  input  1  read request from the datapath (MDR-load side).
REQ-007 write  input  1  write request from the datapath.
REQ-008 address  input  32  word address from MAR; only bits [8:0] used.
REQ-009 data_in  input  32  write data from MDR.
REQ-010 Mdatain  output  32  read data returned to the datapath MDR input.
REQ-011 mem_ready  output  1  access complete; high while the handshake is held.
REQ-012 busy  output  1  high in WAIT and DONE states.
REQ-013 err  output  1  one-cycle pulse on an illegal request.

Function
REQ-014 FSM states: IDLE, WAIT, DONE; 2-bit encoding, IDLE after reset.
REQ-015 IDLE, edge k, exactly one of read/write high: latch address[8:0], data_in and direction; load wait counter with WAIT_CYCLES; go to WAIT.
REQ-016 IDLE, read and write both high: no access, no state change, err high for the following cycle only.
REQ-017 WAIT: counter decrements each edge; the edge where the counter reaches 0 (edge k+WAIT_CYCLES) moves to DONE.
REQ-018 Read commit: Mdatain loaded with mem[latched address] at edge k+WAIT_CYCLES.
REQ-019 Write commit: mem[latched address] written with latched data at edge k+WAIT_CYCLES; Mdatain unchanged.
REQ-020 mem_ready high from edge k+WAIT_CYCLES and stays high throughout DONE.
REQ-021 DONE: at the first edge where read and write are both low, go to IDLE; mem_ready and busy low after that edge.
REQ-022 Four-phase handshake: a request held high past DONE never starts a second access; a new access requires a return through IDLE.
REQ-023 address, data_in, read and write changes during WAIT are ignored; latched values govern the access.
REQ-024 Address bits [31:9] ignored: 0x0000_0200 aliases to word 0; 0x0000_01FF is the last word.
REQ-025 Mdatain holds its last read value between accesses and across writes.
REQ-026 busy equals (state != IDLE); mem_ready equals (state == DONE); both are registered-state decodes with no combinational path from inputs.
REQ-027 Read-after-write to the same address returns the new data.

Reset
REQ-028 clr high: state IDLE, counter 0, Mdatain 0x0000_0000, mem_ready 0, busy 0, err 0, immediately and without a clock edge.
REQ-029 Memory array is not cleared by clr.
REQ-030 clr asserted during WAIT aborts the access; a pending write is not committed.
REQ-031 clr asserted during DONE: an already committed write remains in memory.

Verification
REQ-032 WAIT_CYCLES=2, write=1, address=0x54, data_in=0x0000_0095 at edge k -> busy at k, mem_ready at k+2, mem[0x54]=0x95; drop write -> IDLE at next edge.
REQ-033 Then read=1, address=0x54 -> Mdatain=0x0000_0095 and mem_ready at k+2; Mdatain still 0x95 after the handshake closes.
REQ-034 read=1 and write=1 in IDLE -> err is a single-cycle pulse, busy stays 0, and memory is unchanged.
REQ-035 Write 0xDEAD_BEEF to 0x10, assert clr one cycle into WAIT -> all outputs 0 at once; subsequent read of 0x10 returns the prior contents.
REQ-036 Hold read high for 5 cycles after mem_ready -> exactly one access, mem_ready stays high until read drops; write to address 0x0000_0200 then read 0x0 -> same data.

Source files
------------

// File: rtl/memory_responder.sv
// memory_responder: wait-stated single-port word memory with a four-phase read/write handshake.
module memory_responder #(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clr,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] Mdatain,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [31:0]    data_q, data_d, rdata_q, rdata_d;
  logic           dir_q, dir_d, err_q, err_d, commit;
  logic [31:0]    mem [DEPTH];
  logic           unused_addr;
  assign unused_addr = ^address[31:AW];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rdata_d = rdata_q;
    err_d   = (state_q == IDLE) && read && write;
    commit  = (state_q == WAIT) && (cnt_q == 4'd1);
    case (state_q)
      IDLE: if (read ^ write) begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
        addr_d  = address[AW-1:0];
        data_d  = data_in;
        dir_d   = write;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (commit) begin
          state_d = DONE;
          rdata_d = dir_q ? rdata_q : mem[addr_q];
        end
      end
      DONE: state_d = (!read && !write) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // Array has no reset; clr forces state to IDLE first, so an aborted write never commits.
  always_ff @(posedge clock) begin
    if (commit && dir_q) mem[addr_q] <= data_q;
  end
  assign Mdatain   = rdata_q;
  assign busy      = state_q != IDLE;
  assign mem_ready = state_q == DONE;
  assign err       = err_q;
endmodule
